// File: rtl/countdown_timer_mmss.sv
// rtl/countdown_timer_mmss.sv - BCD mm:ss countdown timer with pause, expiry alarm and load clamping.
// Optional: define COUNTDOWN_AUTO_RELOAD_EN to reload the last preset on expiry instead of alarming.
module countdown_timer_mmss #(
  parameter int MAX_MIN = 59
) (
  input  logic       CLK,
  input  logic       CLEAR,
  input  logic       TICK,
  input  logic       LOAD,
  input  logic [7:0] LOAD_MIN,
  input  logic [7:0] LOAD_SEC,
  input  logic       START,
  input  logic       STOP,
  output logic [7:0] MIN_BCD,
  output logic [7:0] SEC_BCD,
  output logic       RUNNING,
  output logic       DONE,
  output logic       ALARM
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_EXPIRED} state_t;

  localparam logic [3:0] MAX_T = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_O = 4'(MAX_MIN % 10);

  state_t      state;
  logic [7:0]  load_min_c;
  logic [7:0]  load_sec_c;
  logic [15:0] dec_val;
  logic [15:0] reload_val;
  logic        reload_ok;
  logic        count_zero;
  logic        count_one;

  function automatic logic [3:0] sat9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [7:0] clamp_sec(input logic [7:0] v);
    logic [3:0] t;
    t = (v[7:4] > 4'd5) ? 4'd5 : v[7:4];
    return {t, sat9(v[3:0])};
  endfunction

  // Digits are saturated first, then the whole value is limited to MAX_MIN.
  function automatic logic [7:0] clamp_min(input logic [7:0] v);
    logic [3:0] t;
    logic [3:0] o;
    logic [6:0] bin;
    t   = sat9(v[7:4]);
    o   = sat9(v[3:0]);
    bin = {3'b000, t} * 7'd10 + {3'b000, o};
    if (bin > 7'(MAX_MIN)) return {MAX_T, MAX_O};
    return {t, o};
  endfunction

  // Digit-wise borrow chain; only called on a nonzero count.
  function automatic logic [15:0] dec_count(input logic [15:0] v);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = v;
    if (so != 4'd0) so = so - 4'd1;
    else begin
      so = 4'd9;
      if (st != 4'd0) st = st - 4'd1;
      else begin
        st = 4'd5;
        if (mo != 4'd0) mo = mo - 4'd1;
        else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  assign load_min_c = clamp_min(LOAD_MIN);
  assign load_sec_c = clamp_sec(LOAD_SEC);
  assign dec_val    = dec_count({MIN_BCD, SEC_BCD});
  assign count_zero = (MIN_BCD == 8'h00) && (SEC_BCD == 8'h00);
  assign count_one  = (MIN_BCD == 8'h00) && (SEC_BCD == 8'h01);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [15:0] preset;

  always_ff @(negedge CLK or negedge CLEAR) begin
    if (!CLEAR) preset <= 16'h0000;
    else if (LOAD && state != S_RUN) preset <= {load_min_c, load_sec_c};
  end

  assign reload_val = preset;
  assign reload_ok  = (preset != 16'h0000);
`else
  assign reload_val = 16'h0000;
  assign reload_ok  = 1'b0;
`endif

  always_ff @(negedge CLK or negedge CLEAR) begin
    if (!CLEAR) begin
      state   <= S_IDLE;
      MIN_BCD <= 8'h00;
      SEC_BCD <= 8'h00;
      RUNNING <= 1'b0;
      DONE    <= 1'b0;
      ALARM   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (LOAD) begin
            MIN_BCD <= load_min_c;
            SEC_BCD <= load_sec_c;
          end else if (START && !count_zero) begin
            state   <= S_RUN;
            RUNNING <= 1'b1;
          end
        end
        S_RUN: begin
          if (STOP) begin
            state   <= S_PAUSE;
            RUNNING <= 1'b0;
          end else if (TICK && !count_zero) begin
            if (count_one) begin
              DONE <= 1'b1;
              if (reload_ok) begin
                {MIN_BCD, SEC_BCD} <= reload_val;
              end else begin
                MIN_BCD <= 8'h00;
                SEC_BCD <= 8'h00;
                ALARM   <= 1'b1;
                RUNNING <= 1'b0;
                state   <= S_EXPIRED;
              end
            end else begin
              {MIN_BCD, SEC_BCD} <= dec_val;
            end
          end
        end
        S_PAUSE: begin
          if (LOAD) begin
            MIN_BCD <= load_min_c;
            SEC_BCD <= load_sec_c;
          end else if (START) begin
            if (!count_zero) begin
              state   <= S_RUN;
              RUNNING <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_EXPIRED: begin
          if (LOAD) begin
            MIN_BCD <= load_min_c;
            SEC_BCD <= load_sec_c;
            ALARM   <= 1'b0;
            state   <= S_IDLE;
          end else if (STOP) begin
            ALARM <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          state   <= S_IDLE;
          RUNNING <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer_mmss.sv
// tb/tb_countdown_timer_mmss.sv - directed scoreboard bench for countdown_timer_mmss.
module tb_countdown_timer_mmss;

  logic       clk = 1'b1;
  logic       clear = 1'b0;
  logic       tick = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_min = 8'h00;
  logic [7:0] load_sec = 8'h00;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       running;
  logic       done;
  logic       alarm;

  typedef struct {
    logic [7:0] m;
    logic [7:0] s;
    logic       r;
    logic       d;
    logic       a;
  } exp_t;

  exp_t exp_q[$];
  int   n_asserts = 0;
  int   n_fail = 0;

  countdown_timer_mmss #(.MAX_MIN(59)) dut (
    .CLK(clk), .CLEAR(clear), .TICK(tick), .LOAD(load),
    .LOAD_MIN(load_min), .LOAD_SEC(load_sec), .START(start), .STOP(stop),
    .MIN_BCD(min_bcd), .SEC_BCD(sec_bcd), .RUNNING(running), .DONE(done), .ALARM(alarm)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic push(input logic [7:0] m, input logic [7:0] s, input logic r, input logic d,
                      input logic a);
    exp_t e;
    e.m = m; e.s = s; e.r = r; e.d = d; e.a = a;
    exp_q.push_back(e);
  endtask

  task automatic check(input string tag);
    exp_t e;
    n_asserts++;
    assert (exp_q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s queue: observed empty, expected an entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_asserts++;
      assert (min_bcd === e.m) else begin
        n_fail++; $error("FAIL %s min: observed %h expected %h", tag, min_bcd, e.m);
      end
      n_asserts++;
      assert (sec_bcd === e.s) else begin
        n_fail++; $error("FAIL %s sec: observed %h expected %h", tag, sec_bcd, e.s);
      end
      n_asserts++;
      assert (running === e.r) else begin
        n_fail++; $error("FAIL %s running: observed %b expected %b", tag, running, e.r);
      end
      n_asserts++;
      assert (done === e.d) else begin
        n_fail++; $error("FAIL %s done: observed %b expected %b", tag, done, e.d);
      end
      n_asserts++;
      assert (alarm === e.a) else begin
        n_fail++; $error("FAIL %s alarm: observed %b expected %b", tag, alarm, e.a);
      end
    end
  endtask

  // Drive one cycle of inputs on the rising edge, check just after the falling (active) edge.
  task automatic step(input string tag, input logic tk, input logic ld, input logic [7:0] lm,
                      input logic [7:0] ls, input logic st, input logic sp,
                      input logic [7:0] em, input logic [7:0] es, input logic er,
                      input logic ed, input logic ea);
    @(posedge clk);
    tick = tk; load = ld; load_min = lm; load_sec = ls; start = st; stop = sp;
    push(em, es, er, ed, ea);
    @(negedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    #2;
    push(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    check("reset");
    @(posedge clk);
    clear = 1'b1;

    // Reset mid-count
    step("ld0130", 0, 1, 8'h01, 8'h30, 0, 0, 8'h01, 8'h30, 0, 0, 0);
    step("start1", 0, 0, 8'h00, 8'h00, 1, 0, 8'h01, 8'h30, 1, 0, 0);
    step("t129",   1, 0, 8'h00, 8'h00, 0, 0, 8'h01, 8'h29, 1, 0, 0);
    step("t128",   1, 0, 8'h00, 8'h00, 0, 0, 8'h01, 8'h28, 1, 0, 0);
    step("t127",   1, 0, 8'h00, 8'h00, 0, 0, 8'h01, 8'h27, 1, 0, 0);
    step("t126",   1, 0, 8'h00, 8'h00, 0, 0, 8'h01, 8'h26, 1, 0, 0);
    step("t125",   1, 0, 8'h00, 8'h00, 0, 0, 8'h01, 8'h25, 1, 0, 0);
    @(posedge clk);
    tick = 1'b0;
    #2 clear = 1'b0;
    push(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    #1 check("async_clear");
    @(posedge clk);
    clear = 1'b1;

    // Borrow chain
    step("ld1000", 0, 1, 8'h10, 8'h00, 0, 0, 8'h10, 8'h00, 0, 0, 0);
    step("st1000", 0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, 1, 0, 0);
    step("t0959",  1, 0, 8'h00, 8'h00, 0, 0, 8'h09, 8'h59, 1, 0, 0);
    step("stop1",  0, 0, 8'h00, 8'h00, 0, 1, 8'h09, 8'h59, 0, 0, 0);
    step("ld0010", 0, 1, 8'h00, 8'h10, 0, 0, 8'h00, 8'h10, 0, 0, 0);
    step("st0010", 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h10, 1, 0, 0);
    step("t0009",  1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h09, 1, 0, 0);
    step("stop2",  0, 0, 8'h00, 8'h00, 0, 1, 8'h00, 8'h09, 0, 0, 0);
    step("ld0100", 0, 1, 8'h01, 8'h00, 0, 0, 8'h01, 8'h00, 0, 0, 0);
    step("st0100", 0, 0, 8'h00, 8'h00, 1, 0, 8'h01, 8'h00, 1, 0, 0);
    step("t0059",  1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h59, 1, 0, 0);
    step("stop3",  0, 0, 8'h00, 8'h00, 0, 1, 8'h00, 8'h59, 0, 0, 0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    step("ar_ld",   0, 1, 8'h00, 8'h02, 0, 0, 8'h00, 8'h02, 0, 0, 0);
    step("ar_st",   0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h02, 1, 0, 0);
    step("ar_t1",   1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h01, 1, 0, 0);
    step("ar_done", 1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h02, 1, 1, 0);
    step("ar_idle", 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h02, 1, 0, 0);
    step("ar_t3",   1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h01, 1, 0, 0);
    step("ar_done2",1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h02, 1, 1, 0);
    step("ar_stop", 0, 0, 8'h00, 8'h00, 0, 1, 8'h00, 8'h02, 0, 0, 0);
`else
    step("ex_ld",   0, 1, 8'h00, 8'h03, 0, 0, 8'h00, 8'h03, 0, 0, 0);
    step("ex_st",   0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h03, 1, 0, 0);
    step("ex_t2",   1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h02, 1, 0, 0);
    step("ex_t1",   1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h01, 1, 0, 0);
    step("ex_done", 1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 1);
    step("ex_hold", 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1);
    step("ex_tick", 1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1);
    step("ex_strt", 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0, 1);
    step("ex_ack",  0, 0, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00, 0, 0, 0);
    step("ex_st00", 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0, 0);
`endif

    // Pause/resume and input priority
    step("pr_ld",   0, 1, 8'h00, 8'h20, 0, 0, 8'h00, 8'h20, 0, 0, 0);
    step("pr_st",   0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h20, 1, 0, 0);
    step("pr_t19",  1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h19, 1, 0, 0);
    step("pr_t18",  1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h18, 1, 0, 0);
    step("pr_stpt", 1, 0, 8'h00, 8'h00, 0, 1, 8'h00, 8'h18, 0, 0, 0);
    step("pr_res",  0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h18, 1, 0, 0);
    step("pr_t17",  1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h17, 1, 0, 0);
    step("pr_stop", 0, 0, 8'h00, 8'h00, 0, 1, 8'h00, 8'h17, 0, 0, 0);
    step("pr_ldst", 0, 1, 8'h00, 8'h45, 1, 0, 8'h00, 8'h45, 0, 0, 0);
    step("pr_res2", 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h45, 1, 0, 0);
    step("pr_stp2", 0, 0, 8'h00, 8'h00, 0, 1, 8'h00, 8'h45, 0, 0, 0);

    // Clamping and START at 00:00
    step("cl_997c", 0, 1, 8'h99, 8'h7C, 0, 0, 8'h59, 8'h59, 0, 0, 0);
    step("cl_3f0a", 0, 1, 8'h3F, 8'h0A, 0, 0, 8'h39, 8'h09, 0, 0, 0);
    step("cl_a55a", 0, 1, 8'hA5, 8'h5A, 0, 0, 8'h59, 8'h59, 0, 0, 0);
    step("cl_0000", 0, 1, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    step("z_st1",   0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0, 0);
    step("z_st2",   0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
